// File: rtl/nibble_mem_sequencer_if.sv
// Bus bundle between the nibble RAM sequencer and its neighbours:
// the RAM port plus the LOAD source and DUMP sink streams.
interface nibble_mem_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output mem_addr, mem_wdata, mem_we, in_ready, out_valid, out_data,
        input  mem_rdata, in_valid, in_data, out_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, in_ready, out_valid, out_data,
        output mem_rdata, in_valid, in_data, out_ready
    );
endinterface

// File: rtl/nibble_mem_sequencer.sv
// Initiator for the 64 x 4-bit nibble RAM. LOAD streams source nibbles
// into consecutive addresses; DUMP reads consecutive addresses out to a
// sink. Each RAM access occupies CYC_LEN clocks with a stable address.
module nibble_mem_sequencer #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 4,
    parameter int CYC_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    nibble_mem_sequencer_if.master bus
);
    localparam int PH_W = (CYC_LEN > 2) ? $clog2(CYC_LEN) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYC_LEN - 1);
    // Full-RAM transfer length (64 for ADDR_W=6).
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              done_q, done_d;

    logic              last_phase;
    logic              last_nib;
    logic [ADDR_W:0]   cnt_clamped;

    assign last_phase  = (phase_q == PH_LAST);
    assign last_nib    = (rem_q == {{ADDR_W{1'b0}}, 1'b1});
    // Zero and anything beyond the RAM size both mean a full sweep.
    assign cnt_clamped = ((count == '0) || (count > FULL_CNT)) ? FULL_CNT : count;

    // State and datapath registers; everything clears on async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            odata_q <= '0;
            rem_q   <= '0;
            phase_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            odata_q <= odata_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; with ena low every register simply holds.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        odata_d = odata_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        done_d  = done_q;
        if (ena) begin
            done_d = 1'b0;
            if (abort) begin
                // Abort also masks a simultaneous start in IDLE.
                if (state_q != S_IDLE) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            mode_d  = mode;
                            addr_d  = base_addr;
                            rem_d   = cnt_clamped;
                            phase_d = '0;
                            state_d = mode ? S_ACCESS : S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.in_valid) begin
                            wdata_d = bus.in_data;
                            phase_d = '0;
                            state_d = S_ACCESS;
                        end
                    end
                    S_ACCESS: begin
                        if (last_phase) begin
                            phase_d = '0;
                            if (mode_q) begin
                                odata_d = bus.mem_rdata;
                                state_d = S_HOLD;
                            end else begin
                                addr_d  = addr_q + 1'b1;
                                rem_d   = rem_q - 1'b1;
                                done_d  = last_nib;
                                state_d = last_nib ? S_IDLE : S_WAIT;
                            end
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (bus.out_ready) begin
                            addr_d  = addr_q + 1'b1;
                            rem_d   = rem_q - 1'b1;
                            done_d  = last_nib;
                            state_d = last_nib ? S_IDLE : S_ACCESS;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Strobes are gated by ena/abort so a frozen or aborted cycle has no effect.
    assign bus.in_ready  = ena & ~abort & (state_q == S_WAIT);
    assign bus.mem_we    = ena & ~abort & (state_q == S_ACCESS) & ~mode_q & last_phase;
    assign bus.out_valid = (state_q == S_HOLD) & ~(ena & abort);
    assign bus.out_data  = odata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q & ena;
endmodule

// File: tb/tb_nibble_mem_sequencer.sv
// Directed bench for nibble_mem_sequencer with a behavioural 64x4 RAM.
module tb_nibble_mem_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, ena, start, abort, mode;
    logic [5:0] base_addr;
    logic [6:0] count;
    logic       busy, done;

    nibble_mem_sequencer_if #(.ADDR_W(6), .DATA_W(4)) bus ();

    nibble_mem_sequencer #(.ADDR_W(6), .DATA_W(4), .CYC_LEN(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
        .mode(mode), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, write on posedge; bench preload port.
    logic [3:0] ram [64];
    logic       pre_we = 1'b0;
    logic [5:0] pre_addr = '0;
    logic [3:0] pre_data = '0;
    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int a; int d; int c; } ent_t;
    ent_t wlog[$];
    ent_t olog[$];
    int   dlog[$];
    int   dbusy[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we) wlog.push_back('{int'(bus.mem_addr), int'(bus.mem_wdata), cyc});
            if (bus.out_valid && bus.out_ready)
                olog.push_back('{int'(bus.out_data), int'(bus.mem_addr), cyc});
            if (done) begin
                dlog.push_back(cyc);
                dbusy.push_back(int'(busy));
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int last_hs = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wlog.delete();
        olog.delete();
        dlog.delete();
        dbusy.delete();
    endtask

    task automatic preload(input int a, input int d);
        pre_addr = 6'(a);
        pre_data = 4'(d);
        pre_we   = 1'b1;
        step(1);
        pre_we   = 1'b0;
    endtask

    task automatic kick(input logic m, input int b, input int n);
        mode      = m;
        base_addr = 6'(b);
        count     = 7'(n);
        start     = 1'b1;
        step(1);
        start     = 1'b0;
    endtask

    task automatic push_nib(input int d);
        int got;
        got = 0;
        bus.in_data  = 4'(d);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 40 && got == 0; k++) begin
            if (bus.in_ready) begin
                last_hs = cyc;
                got = 1;
            end
            step(1);
        end
        chk("push_handshake", got, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 1000 && busy; k++) step(1);
        chk("idle_reached", int'(busy), 0);
    endtask

    initial begin
        int t0, h, bad, d0, a0;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        base_addr = '0; count = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        step(2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(bus.mem_we), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_addr", int'(bus.mem_addr), 0);
        chk("rst_wdata", int'(bus.mem_wdata), 0);
        chk("rst_odata", int'(bus.out_data), 0);
        rst_n = 1'b1;
        step(2);

        // LOAD base 5, three nibbles, source always valid
        clear_logs();
        kick(1'b0, 5, 3);
        chk("ld3_busy", int'(busy), 1);
        push_nib(10); push_nib(11); push_nib(12);
        wait_idle();
        step(2);
        bus.in_valid = 1'b0;
        chk("ld3_nwr", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("ld3_a0", wlog[0].a, 5);  chk("ld3_d0", wlog[0].d, 10);
            chk("ld3_a1", wlog[1].a, 6);  chk("ld3_d1", wlog[1].d, 11);
            chk("ld3_a2", wlog[2].a, 7);  chk("ld3_d2", wlog[2].d, 12);
            chk("ld3_gap1", wlog[1].c - wlog[0].c, 9);
            chk("ld3_gap2", wlog[2].c - wlog[1].c, 9);
            chk("ld3_lat", wlog[2].c - last_hs, 8);
        end
        chk("ld3_ndone", dlog.size(), 1);
        if (dlog.size() == 1 && wlog.size() == 3) begin
            chk("ld3_done_cyc", dlog[0], wlog[2].c + 1);
            chk("ld3_done_busy", dbusy[0], 0);
        end
        chk("ld3_ram7", int'(ram[7]), 12);

        // LOAD count=0: full 64-nibble sweep, then an extra nibble is refused
        clear_logs();
        kick(1'b0, 0, 0);
        for (int i = 0; i < 64; i++) push_nib(i % 16);
        bus.in_data = 4'h5;
        wait_idle();
        step(5);
        chk("ld64_in_ready", int'(bus.in_ready), 0);
        chk("ld64_busy", int'(busy), 0);
        chk("ld64_nwr", wlog.size(), 64);
        chk("ld64_ndone", dlog.size(), 1);
        bad = 0;
        for (int i = 0; i < 64; i++) if (int'(ram[i]) != i % 16) bad++;
        chk("ld64_ram_bad", bad, 0);
        bus.in_valid = 1'b0;

        // DUMP across the address wrap, sink always ready
        preload(62, 3); preload(63, 4); preload(0, 5);
        clear_logs();
        bus.out_ready = 1'b1;
        t0 = cyc;
        kick(1'b1, 62, 3);
        wait_idle();
        step(2);
        chk("dw_nout", olog.size(), 3);
        if (olog.size() == 3) begin
            chk("dw_d0", olog[0].a, 3);  chk("dw_a0", olog[0].d, 62);
            chk("dw_d1", olog[1].a, 4);  chk("dw_a1", olog[1].d, 63);
            chk("dw_d2", olog[2].a, 5);  chk("dw_a2", olog[2].d, 0);
            chk("dw_lat", olog[0].c - t0, 9);
            chk("dw_gap", olog[1].c - olog[0].c, 9);
        end
        chk("dw_ndone", dlog.size(), 1);

        // DUMP with sink backpressure
        preload(10, 9); preload(11, 6);
        clear_logs();
        bus.out_ready = 1'b0;
        kick(1'b1, 10, 2);
        for (int k = 0; k < 20 && !bus.out_valid; k++) step(1);
        chk("bp_valid", int'(bus.out_valid), 1);
        d0 = int'(bus.out_data);
        a0 = int'(bus.mem_addr);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.out_valid || int'(bus.out_data) != d0 || int'(bus.mem_addr) != a0) bad++;
            step(1);
        end
        chk("bp_stable", bad, 0);
        chk("bp_data_held", d0, 9);
        chk("bp_none_yet", olog.size(), 0);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        step(2);
        chk("bp_one", olog.size(), 1);
        chk("bp_busy_mid", int'(busy), 1);
        bus.out_ready = 1'b1;
        wait_idle();
        step(2);
        chk("bp_two", olog.size(), 2);
        if (olog.size() == 2) begin
            chk("bp_d0", olog[0].a, 9);
            chk("bp_d1", olog[1].a, 6);
            chk("bp_a1", olog[1].d, 11);
        end
        chk("bp_ndone", dlog.size(), 1);
        bus.out_ready = 1'b0;

        // Abort during phase 3 of the second LOAD nibble
        preload(21, 15);
        clear_logs();
        kick(1'b0, 20, 4);
        push_nib(1);
        push_nib(2);
        step(3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("ab_busy", int'(busy), 0);
        chk("ab_in_ready", int'(bus.in_ready), 0);
        step(10);
        bus.in_valid = 1'b0;
        chk("ab_nwr", wlog.size(), 1);
        chk("ab_ram20", int'(ram[20]), 1);
        chk("ab_ram21", int'(ram[21]), 15);
        chk("ab_ndone", dlog.size(), 0);

        // ena low for 10 clocks on the write phase
        clear_logs();
        kick(1'b0, 30, 1);
        push_nib(7);
        h = last_hs;
        step(7);
        ena = 1'b0;
        step(10);
        ena = 1'b1;
        chk("en_frozen_nwr", wlog.size(), 0);
        chk("en_frozen_busy", int'(busy), 1);
        step(3);
        wait_idle();
        step(2);
        bus.in_valid = 1'b0;
        chk("en_nwr", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("en_wr_cyc", wlog[0].c - h, 18);
            chk("en_wr_addr", wlog[0].a, 30);
            chk("en_wr_data", wlog[0].d, 7);
        end
        chk("en_ndone", dlog.size(), 1);

        // Async reset while DUMP holds a nibble
        preload(40, 10);
        clear_logs();
        kick(1'b1, 40, 3);
        for (int k = 0; k < 20 && !bus.out_valid; k++) step(1);
        chk("ar_pre_valid", int'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", int'(bus.out_valid), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_addr", int'(bus.mem_addr), 0);
        chk("ar_odata", int'(bus.out_data), 0);
        chk("ar_done", int'(done), 0);
        #10;
        rst_n = 1'b1;
        step(1);
        clear_logs();
        bus.out_ready = 1'b1;
        step(15);
        chk("ar_after_busy", int'(busy), 0);
        chk("ar_after_nout", olog.size(), 0);
        chk("ar_after_ndone", dlog.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
